// File: rtl/nv_csa_resolve_acc_if.sv
// Beat-in / result-out bus of the carry-save accumulator.
// slave is the accumulator's view, master is the producer/consumer side.
interface nv_csa_resolve_acc_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_pvld;
  logic             in_prdy;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             in_last;
  logic             out_pvld;
  logic             out_prdy;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;

  modport slave (
    input  in_pvld, in_sum, in_carry, in_last, out_prdy,
    output in_prdy, out_pvld, out_data, out_cnt
  );

  modport master (
    output in_pvld, in_sum, in_carry, in_last, out_prdy,
    input  in_prdy, out_pvld, out_data, out_cnt
  );
endinterface

// File: rtl/nv_csa_resolve_acc.sv
// Carry-save accumulator: 4:2 compresses each beat into (acc_s, acc_c), then
// resolves the pair CHUNK bits per cycle with a rippled carry on the last beat.
module nv_csa_resolve_acc #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  nv_csa_resolve_acc_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ST_ACC = 2'd0;
  localparam logic [1:0] ST_RES = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] acc_s_q, acc_c_q, res_q, out_data_q;
  logic [CNT_W-1:0] cnt_q, out_cnt_q;
  logic [KW-1:0]    k_q;
  logic             cin_q, out_pvld_q;

  logic [WIDTH-1:0] s1, c1, s2_d, c2_d, res_d;
  logic [CHUNK-1:0] cs, cc, csum;
  logic             cout;
  logic             acc_fire, k_last;

  assign bus.in_prdy  = (state_q == ST_ACC);
  assign bus.out_pvld = out_pvld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_cnt  = out_cnt_q;

  assign acc_fire = bus.in_pvld && (state_q == ST_ACC);
  assign k_last   = (k_q == KW'(NCHUNK - 1));

  // Two 3:2 levels; carries are weighted one bit up, so the MSB falls off (mod 2^WIDTH).
  always_comb begin
    s1   = acc_s_q ^ acc_c_q ^ bus.in_sum;
    c1   = ((acc_s_q & acc_c_q) | (acc_s_q & bus.in_sum) | (acc_c_q & bus.in_sum)) << 1;
    s2_d = s1 ^ c1 ^ bus.in_carry;
    c2_d = ((s1 & c1) | (s1 & bus.in_carry) | (c1 & bus.in_carry)) << 1;
  end

  always_comb begin
    cs = '0;
    cc = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        cs = acc_s_q[i*CHUNK +: CHUNK];
        cc = acc_c_q[i*CHUNK +: CHUNK];
      end
    end
    {cout, csum} = {1'b0, cs} + {1'b0, cc} + {{CHUNK{1'b0}}, cin_q};
    res_d = res_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) res_d[i*CHUNK +: CHUNK] = csum;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= ST_ACC;
      acc_s_q    <= '0;
      acc_c_q    <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      cin_q      <= 1'b0;
      res_q      <= '0;
      out_pvld_q <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_ACC: if (acc_fire) begin
          acc_s_q <= s2_d;
          acc_c_q <= c2_d;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (bus.in_last) begin
            state_q <= ST_RES;
            k_q     <= '0;
            cin_q   <= 1'b0;
          end
        end
        ST_RES: begin
          res_q <= res_d;
          cin_q <= cout;
          k_q   <= k_q + 1'b1;
          if (k_last) begin
            out_data_q <= res_d;
            out_cnt_q  <= cnt_q;
            out_pvld_q <= 1'b1;
            state_q    <= ST_OUT;
          end
        end
        ST_OUT: if (bus.out_prdy) begin
          out_pvld_q <= 1'b0;
          acc_s_q    <= '0;
          acc_c_q    <= '0;
          cnt_q      <= '0;
          state_q    <= ST_ACC;
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_nv_csa_resolve_acc.sv
// Randomized and directed checks of nv_csa_resolve_acc against a plain-sum model.
module tb_nv_csa_resolve_acc;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int CNT_W = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk, rstn;
  int   errs = 0, checks = 0;

  nv_csa_resolve_acc_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  nv_csa_resolve_acc #(.WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and return right after the edge that accepts it.
  task automatic send_beat(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input logic last);
    int n;
    @(negedge clk);
    bus.in_pvld = 1'b1; bus.in_sum = s; bus.in_carry = c; bus.in_last = last;
    n = 0;
    while (!bus.in_prdy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("in_prdy_timeout", 0, 1);
    @(posedge clk);
  endtask

  // Called just after the last-beat accept edge: latency, result, handshake, bubble.
  task automatic get_result(input string tag, input logic [WIDTH-1:0] ed, input logic [CNT_W-1:0] ec,
                            input int stall);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1; lat++;
      if (bus.out_pvld) break;
    end
    chk({tag, "_lat"}, lat, NCHUNK);
    chk({tag, "_data"}, bus.out_data, ed);
    chk({tag, "_cnt"}, bus.out_cnt, ec);
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_hold"}, {bus.out_pvld, bus.in_prdy, bus.out_cnt, bus.out_data}, {2'b10, ec, ed});
    end
    @(negedge clk); bus.out_prdy = 1'b1;
    @(posedge clk); #1; bus.out_prdy = 1'b0;
    chk({tag, "_post"}, {bus.out_pvld, bus.in_prdy, bus.out_data}, {2'b01, ed});
  endtask

  initial begin
    logic [WIDTH-1:0] s, c, exp_d;
    int nb, ec;

    rstn = 1'b0;
    bus.in_pvld = 1'b0; bus.in_sum = '0; bus.in_carry = '0; bus.in_last = 1'b0; bus.out_prdy = 1'b0;
    #12;
    chk("rst_state", {bus.out_pvld, bus.out_data, bus.out_cnt}, '0);
    @(negedge clk); rstn = 1'b1;
    #1 chk("rst_prdy", bus.in_prdy, 1);

    send_beat(32'h000000FF, 32'h1, 1'b1); #1 bus.in_pvld = 1'b0;
    get_result("one", 32'h100, 1, 0);

    send_beat(32'hFFFFFFFF, 32'h1, 1'b1); #1 bus.in_pvld = 1'b0;
    get_result("wrap", 32'h0, 1, 0);

    send_beat(32'h10, 32'h20, 1'b0);
    send_beat(32'h30, 32'h40, 1'b0);
    send_beat(32'h50, 32'h60, 1'b1); #1 bus.in_pvld = 1'b0;
    get_result("three", 32'h150, 3, 0);

    // Stall with junk beats offered; they must be ignored.
    send_beat(32'h1234, 32'h1000, 1'b1);
    #1 bus.in_sum = 32'hDEAD; bus.in_carry = 32'hBEEF; bus.in_last = 1'b1;
    repeat (NCHUNK) @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {bus.out_pvld, bus.in_prdy, bus.out_cnt, bus.out_data}, {2'b10, 16'd1, 32'h2234});
    end
    bus.in_pvld = 1'b0;
    bus.out_prdy = 1'b1;
    @(posedge clk); #1 bus.out_prdy = 1'b0;
    chk("stall_post", {bus.out_pvld, bus.in_prdy}, 2'b01);
    send_beat(32'h1, 32'h2, 1'b1); #1 bus.in_pvld = 1'b0;
    get_result("after_stall", 32'h3, 1, 0);

    // Reset in the middle of resolving chunk 2.
    send_beat(32'h55, 32'h11, 1'b1); #1 bus.in_pvld = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk("mid_rst", {bus.out_pvld, bus.out_data, bus.out_cnt}, '0);
    @(negedge clk); rstn = 1'b1;
    send_beat(32'h7, 32'h0, 1'b1); #1 bus.in_pvld = 1'b0;
    get_result("post_rst", 32'h7, 1, 0);

    // Random packets vs. plain modular sum.
    for (int p = 0; p < 25; p++) begin
      nb = $urandom_range(1, 6);
      exp_d = '0;
      for (int b = 0; b < nb; b++) begin
        s = $urandom(); c = $urandom();
        if ($urandom_range(0, 1) == 0) c[0] = 1'b0;
        exp_d = exp_d + s + c;
        send_beat(s, c, (b == nb - 1));
        if ($urandom_range(0, 2) == 0) begin #1 bus.in_pvld = 1'b0; end
      end
      #1 bus.in_pvld = 1'b0;
      get_result("rand", exp_d, CNT_W'(nb), $urandom_range(0, 3));
    end

    // Counter saturation: 70000 beats of 1.
    ec = 70000;
    @(negedge clk);
    bus.in_pvld = 1'b1; bus.in_sum = 32'h1; bus.in_carry = 32'h0; bus.in_last = 1'b0;
    repeat (ec - 1) @(posedge clk);
    @(negedge clk); bus.in_last = 1'b1;
    @(posedge clk); #1 bus.in_pvld = 1'b0;
    get_result("sat", 32'(ec), 16'hFFFF, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
